// File: rtl/add_3bit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : add_3bit
//  Purpose  : 3-bit unsigned adder with carry-in. It is built as a ripple
//             chain of three 1-bit full adders. The sum and carry-out are
//             available combinationally, and a registered copy is also given.
//  Ports    :
//    clk    in   1  rising-edge clock for the output registers
//    rst_n  in   1  asynchronous active-low reset (registered outputs only)
//    A      in   3  unsigned addend
//    B      in   3  unsigned addend
//    Cin    in   1  carry-in, weight 1
//    Sum    out  3  combinational A+B+Cin, bits [2:0]
//    Cout   out  1  combinational A+B+Cin, bit 3
//    Sum_q  out  3  Sum registered one cycle later
//    Cout_q out  1  Cout registered one cycle later
//  Revision : 1.0  initial release
// ============================================================================
module add_3bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] A,
  input  logic [2:0] B,
  input  logic       Cin,
  output logic [2:0] Sum,
  output logic       Cout,
  output logic [2:0] Sum_q,
  output logic       Cout_q
);

  localparam int unsigned c_WIDTH = 3;

  // w_carry[i] is the carry into stage i; w_carry[c_WIDTH] is the final carry-out.
  logic [c_WIDTH:0]   w_carry;
  logic [c_WIDTH-1:0] w_sum;

  logic [c_WIDTH-1:0] r_sum_q;
  logic               r_cout_q;

  assign w_carry[0] = Cin;

  generate
    for (genvar gi = 0; gi < c_WIDTH; gi++) begin : g_stage
      logic w_p;  // propagate term a^b, shared by the sum and carry equations

      assign w_p            = A[gi] ^ B[gi];
      assign w_sum[gi]      = w_p ^ w_carry[gi];
      assign w_carry[gi+1]  = (A[gi] & B[gi]) | (w_carry[gi] & w_p);
    end
  endgenerate

  // The combinational outputs do not depend on clk or rst_n.
  assign Sum  = w_sum;
  assign Cout = w_carry[c_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum_q  <= '0;
      r_cout_q <= 1'b0;
    end else begin
      r_sum_q  <= w_sum;
      r_cout_q <= w_carry[c_WIDTH];
    end
  end

  assign Sum_q  = r_sum_q;
  assign Cout_q = r_cout_q;

endmodule
`default_nettype wire

// File: tb/tb_add_3bit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_add_3bit
//  Purpose  : Self-checking bench for add_3bit. It applies directed vectors,
//             an exhaustive combinational sweep, randomized clocked traffic,
//             and reset corner sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_add_3bit;

  logic       clk;
  logic       rst_n;
  logic [2:0] A;
  logic [2:0] B;
  logic       Cin;
  logic [2:0] Sum;
  logic       Cout;
  logic [2:0] Sum_q;
  logic       Cout_q;

  int checks;
  int errors;

  add_3bit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .Cin    (Cin),
    .Sum    (Sum),
    .Cout   (Cout),
    .Sum_q  (Sum_q),
    .Cout_q (Cout_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic       cin;
    logic [2:0] sum;
    logic       cout;
  } vec_t;

  // Reference model: plain integer addition, split into carry and low bits.
  function automatic logic [3:0] ref_add(input int a, input int b, input int c);
    int r;
    r = a + b + c;
    return 4'(r);
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (A=%0d B=%0d Cin=%0d)", name, act, exp, A, B, Cin);
    end
  endtask

  vec_t vecs [6];
  logic [3:0] exp_v;

  initial begin
    checks = 0;
    errors = 0;

    vecs[0] = '{a: 3'd0, b: 3'd0, cin: 1'b0, sum: 3'd0, cout: 1'b0};
    vecs[1] = '{a: 3'd5, b: 3'd2, cin: 1'b0, sum: 3'd7, cout: 1'b0};
    vecs[2] = '{a: 3'd3, b: 3'd4, cin: 1'b1, sum: 3'd0, cout: 1'b1};
    vecs[3] = '{a: 3'd7, b: 3'd7, cin: 1'b1, sum: 3'd7, cout: 1'b1};
    vecs[4] = '{a: 3'd4, b: 3'd4, cin: 1'b0, sum: 3'd0, cout: 1'b1};
    vecs[5] = '{a: 3'd1, b: 3'd6, cin: 1'b0, sum: 3'd7, cout: 1'b0};

    rst_n = 1'b0;
    A     = 3'd0;
    B     = 3'd0;
    Cin   = 1'b0;

    // Reset state: the registered outputs are cleared with no clock edge.
    #1;
    check("reset_q_initial", {Cout_q, Sum_q}, 4'd0);

    // Directed vectors while reset is held. This shows that the combinational
    // path ignores reset.
    for (int i = 0; i < 6; i++) begin
      A   = vecs[i].a;
      B   = vecs[i].b;
      Cin = vecs[i].cin;
      #5;
      check($sformatf("vec%0d", i), {Cout, Sum}, {vecs[i].cout, vecs[i].sum});
    end
    check("reset_q_held", {Cout_q, Sum_q}, 4'd0);

    // Exhaustive sweep with 5-unit steps.
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        for (int c = 0; c < 2; c++) begin
          A   = 3'(a);
          B   = 3'(b);
          Cin = 1'(c);
          #5;
          check("sweep", {Cout, Sum}, ref_add(a, b, c));
        end

    // Release reset between edges, then apply A=6, B=3, Cin=0.
    @(negedge clk);
    rst_n = 1'b1;
    A = 3'd6; B = 3'd3; Cin = 1'b0;
    @(posedge clk);
    #1;
    check("clk_6p3_q", {Cout_q, Sum_q}, 4'b1001);
    check("clk_6p3_comb", {Cout, Sum}, 4'b1001);

    // Reset asserted mid-cycle clears the registers at once and leaves the
    // combinational outputs unchanged.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_q", {Cout_q, Sum_q}, 4'd0);
    check("async_rst_comb", {Cout, Sum}, 4'b1001);
    @(posedge clk);
    #1;
    check("rst_hold_over_edge", {Cout_q, Sum_q}, 4'd0);

    // The first edge after release loads the current sum.
    @(negedge clk);
    rst_n = 1'b1;
    A = 3'd7; B = 3'd7; Cin = 1'b1;
    #1;
    check("post_release_before_edge", {Cout_q, Sum_q}, 4'd0);
    @(posedge clk);
    #1;
    check("post_release_first_edge", {Cout_q, Sum_q}, 4'd15);

    // Randomized clocked traffic. The register follows the model with a
    // 1-cycle delay.
    for (int n = 0; n < 200; n++) begin
      int ra, rb, rc;
      @(negedge clk);
      ra = int'($urandom_range(7, 0));
      rb = int'($urandom_range(7, 0));
      rc = int'($urandom_range(1, 0));
      A = 3'(ra); B = 3'(rb); Cin = 1'(rc);
      exp_v = ref_add(ra, rb, rc);
      #1;
      check("rand_comb", {Cout, Sum}, exp_v);
      @(posedge clk);
      #1;
      check("rand_q", {Cout_q, Sum_q}, exp_v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/add_3bit.md
ADD_3BIT -- requirements
Module: add_3bit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 3 bits.
REQ-002 clk  input  1  sole clock; all registers update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 A  input  3  unsigned addend.
REQ-005 B  input  3  unsigned addend.
REQ-006 Cin  input  1  carry-in, weight 1.
REQ-007 Sum  output  3  combinational sum bits [2:0] of A+B+Cin.
REQ-008 Cout  output  1  combinational carry-out, bit 3 of A+B+Cin.
REQ-009 Sum_q  output  3  registered copy of Sum.
REQ-010 Cout_q  output  1  registered copy of Cout.

Function
REQ-011 {Cout,Sum} SHALL equal A+B+Cin as a 4-bit unsigned result, for all 128 input combinations.
REQ-012 Sum and Cout SHALL be purely combinational, with zero clock latency.
REQ-013 Sum and Cout SHALL be independent of clk and rst_n.
REQ-014 Sum and Cout SHALL be valid within one settle delay of any input change.
REQ-015 The adder SHALL be built as a 3-stage ripple-carry chain of 1-bit full adders.
REQ-016 Each full-adder stage SHALL compute s = a^b^c and co = (a&b)|(c&(a^b)).
REQ-017 Stage i carry-out SHALL drive stage i+1 carry-in; Cin SHALL feed stage 0 and stage 2 carry-out SHALL drive Cout.
REQ-018 Maximum result 7+7+1 = 15 SHALL give Sum=7 and Cout=1, with no wrap beyond 4 bits.
REQ-019 Any result >= 8 SHALL set Cout=1, with Sum holding the result minus 8.
REQ-020 Sum_q and Cout_q SHALL capture Sum and Cout on each rising clk edge while rst_n=1, giving 1-cycle latency.
REQ-021 There is no enable or handshake; the registers SHALL load on every cycle.
REQ-022 No input value combination, X-free, SHALL produce X on any output.

Reset
REQ-023 While rst_n=0, Sum_q SHALL be 3'b000 and Cout_q SHALL be 0, forced immediately without waiting for clk.
REQ-024 Reset SHALL NOT affect the combinational Sum and Cout outputs.
REQ-025 After rst_n rises, the first rising clk edge SHALL load the current Sum and Cout into Sum_q and Cout_q.
REQ-026 Reset asserted mid-operation SHALL clear Sum_q and Cout_q asynchronously; the combinational path SHALL continue uninterrupted.

Verification
REQ-027 A=0, B=0, Cin=0 -> Sum=0, Cout=0.
REQ-028 A=5, B=2, Cin=0 -> Sum=7, Cout=0; A=3, B=4, Cin=1 -> Sum=0, Cout=1.
REQ-029 A=7, B=7, Cin=1 -> Sum=7, Cout=1.
REQ-030 Exhaustive sweep of A 0..7, B 0..7, Cin 0..1, with 5-time-unit steps and no clock required -> every {Cout,Sum} equals A+B+Cin.
REQ-031 Clocked run with A=6, B=3, Cin=0 -> Sum_q=1 and Cout_q=1 after one rising edge.
REQ-032 In the REQ-031 run, drive rst_n low between edges -> Sum_q=0 and Cout_q=0 immediately, while Sum=1 and Cout=1 are unchanged.
